// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 divider.
// State encoding, iteration count, divide-by-zero fill.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_ITERS = 32;

  // Every quotient bit takes this value on a zero divisor.
  localparam logic DZ_QUOT_BIT = 1'b1;

endpackage

// File: rtl/div_if.sv
// Request/result bundle between the execute stage and the divider.
// The master issues the operands; the slave returns stall and results.
interface div_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, signed_div, a, b, cancel,
    input  stall, busy, done,
    input  quotient, remainder, div_zero
  );

  modport slave (
    input  start, signed_div, a, b, cancel,
    output stall, busy, done,
    output quotient, remainder, div_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep or restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;

  assign sh    = {rem_i, msb_i};
  assign diff  = sh - {1'b0, dvs_i};
  assign q_o   = ~diff[WIDTH];
  assign rem_o = q_o ? diff[WIDTH-1:0] : sh[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit; one quotient bit per cycle.
// Quotient builds up in the dividend register as it shifts out.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input logic clk,
  input logic rst,
  div_if.slave io
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] qmag;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;
  logic             last;

  assign a_neg  = io.signed_div & io.a[WIDTH-1];
  assign b_neg  = io.signed_div & io.b[WIDTH-1];
  assign a_mag  = a_neg ? -io.a : io.a;
  assign b_mag  = b_neg ? -io.b : io.b;
  assign b_zero = (io.b == '0);
  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign qmag   = {dvd_q[WIDTH-2:0], step_q};

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i(rem_q),
    .msb_i(dvd_q[WIDTH-1]),
    .dvs_i(dvs_q),
    .rem_o(step_rem),
    .q_o  (step_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; cancel wins over start and over completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (io.cancel)     state_d = IDLE;
        else if (io.start) state_d = b_zero ? DONE : RUN;
      end
      RUN: begin
        if (io.cancel)     state_d = IDLE;
        else if (last)     state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    io.stall = (io.start && state_q == IDLE)
             || state_q == RUN;
    io.busy  = (state_q == RUN);
    io.done  = (state_q == DONE);
  end

  assign io.quotient  = quo_q;
  assign io.remainder = rmd_q;
  assign io.div_zero  = dz_q;

  // Datapath next state: latch operands, iterate, sign-fix.
  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    rmd_d  = rmd_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    unique case (state_q)
      IDLE: begin
        if (io.start && !io.cancel) begin
          if (b_zero) begin
            quo_d = {WIDTH{DZ_QUOT_BIT}};
            rmd_d = io.a;
            dz_d  = 1'b1;
          end else begin
            rem_d  = '0;
            dvd_d  = a_mag;
            dvs_d  = b_mag;
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
            cnt_d  = '0;
          end
        end
      end
      RUN: begin
        if (!io.cancel) begin
          rem_d = step_rem;
          dvd_d = qmag;
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            quo_d = qneg_q ? -qmag : qmag;
            rmd_d = rneg_q ? -step_rem : step_rem;
            dz_d  = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      rmd_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
      rmd_q  <= rmd_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
    end
  end

endmodule
